// File: rtl/answer_checker_pkg.sv
// Shared definitions for the answer checker: controller state encoding,
// parameter defaults and the saturating score helper.
package answer_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT      = 3'd1,
    ST_SHOW_OK   = 3'd2,
    ST_SHOW_BAD  = 3'd3,
    ST_SHOW_FAIL = 3'd4
  } state_e;

  localparam int unsigned DEF_MAX_TRIES     = 3;
  localparam int unsigned DEF_RESULT_CYCLES = 4;
  localparam logic [3:0]  SCORE_MAX         = 4'd15;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == SCORE_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/answer_checker_result_timer.sv
// Result hold timer: loads CYCLES, counts down to zero, and flags the last
// held cycle so the controller leaves its SHOW state on that edge.
module result_timer #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = 4'(CYCLES);
    end else if (count_q != 4'd0) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == 4'd1);

endmodule

// File: rtl/answer_checker.sv
// Quiz round controller: captures a target, judges submitted answers, holds
// a result flag for RESULT_CYCLES cycles and keeps a saturating score.
module answer_checker
  import answer_checker_pkg::*;
#(
  parameter int unsigned MAX_TRIES     = DEF_MAX_TRIES,
  parameter int unsigned RESULT_CYCLES = DEF_RESULT_CYCLES
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic [3:0] Sum,
  input  logic [3:0] Answer,
  input  logic       Submit,
  output logic       Busy,
  output logic       Correct,
  output logic       Wrong,
  output logic       Fail,
  output logic       RoundDone,
  output logic [3:0] Score,
  output logic [1:0] TriesLeft,
  output state_e     dbg_state
);

  // Start and Submit are single-cycle request pulses with no ready/back-pressure:
  // a pulse is acted on only when the controller is in the state that accepts it
  // (Start in IDLE, Submit in WAIT) and is silently dropped otherwise.

  state_e     state_q, state_d;
  logic [3:0] target_q, target_d;
  logic [3:0] score_q, score_d;
  logic [1:0] tries_q, tries_d;
  logic       busy_q, busy_d;
  logic       correct_q, correct_d;
  logic       wrong_q, wrong_d;
  logic       fail_q, fail_d;
  logic       round_done_q, round_done_d;
  logic       timer_load;
  logic       timer_done;

  result_timer #(
    .CYCLES(RESULT_CYCLES)
  ) u_timer (
    .clk (Clk),
    .rst (Rst),
    .load(timer_load),
    .done(timer_done)
  );

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    score_d      = score_q;
    tries_d      = tries_q;
    round_done_d = 1'b0;
    timer_load   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          target_d = Sum;
          tries_d  = 2'(MAX_TRIES);
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (Submit) begin
          timer_load = 1'b1;
          if (Answer == target_q) begin
            score_d = sat_inc(score_q);
            state_d = ST_SHOW_OK;
          end else begin
            tries_d = tries_q - 2'd1;
            state_d = (tries_q == 2'd1) ? ST_SHOW_FAIL : ST_SHOW_BAD;
          end
        end
      end
      ST_SHOW_OK, ST_SHOW_FAIL: begin
        if (timer_done) begin
          state_d      = ST_IDLE;
          round_done_d = 1'b1;
        end
      end
      ST_SHOW_BAD: begin
        if (timer_done) begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flags are decoded from the next state so they line up with it when registered.
    busy_d    = (state_d != ST_IDLE);
    correct_d = (state_d == ST_SHOW_OK);
    wrong_d   = (state_d == ST_SHOW_BAD);
    fail_d    = (state_d == ST_SHOW_FAIL);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      target_q     <= 4'd0;
      score_q      <= 4'd0;
      tries_q      <= 2'd0;
      busy_q       <= 1'b0;
      correct_q    <= 1'b0;
      wrong_q      <= 1'b0;
      fail_q       <= 1'b0;
      round_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      score_q      <= score_d;
      tries_q      <= tries_d;
      busy_q       <= busy_d;
      correct_q    <= correct_d;
      wrong_q      <= wrong_d;
      fail_q       <= fail_d;
      round_done_q <= round_done_d;
    end
  end

  assign Busy      = busy_q;
  assign Correct   = correct_q;
  assign Wrong     = wrong_q;
  assign Fail      = fail_q;
  assign RoundDone = round_done_q;
  assign Score     = score_q;
  assign TriesLeft = tries_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_answer_checker.sv
// Bench for answer_checker: directed vector table, hand-written corner
// sequences and randomized rounds judged by a round-level reference model.
module tb_answer_checker;
  import answer_checker_pkg::*;

  localparam int MT = 3;
  localparam int RC = 4;
  localparam int K_OK = 0;
  localparam int K_BAD = 1;
  localparam int K_FAIL = 2;

  logic       clk = 1'b0;
  logic       rst, start, submit;
  logic [3:0] sum, answer;
  logic       busy, correct, wrong, fail, round_done;
  logic [3:0] score;
  logic [1:0] tries_left;
  state_e     dbg_state;

  int checks = 0;
  int failures = 0;

  // reference model of the game rules
  int m_target, m_tries, m_score;

  typedef struct {
    bit         new_round;
    logic [3:0] sum;
    logic [3:0] ans;
    int         kind;
    int         tries;
    int         score;
  } vec_t;

  vec_t vecs[10];

  answer_checker #(
    .MAX_TRIES    (MT),
    .RESULT_CYCLES(RC)
  ) dut (
    .Clk      (clk),
    .Rst      (rst),
    .Start    (start),
    .Sum      (sum),
    .Answer   (answer),
    .Submit   (submit),
    .Busy     (busy),
    .Correct  (correct),
    .Wrong    (wrong),
    .Fail     (fail),
    .RoundDone(round_done),
    .Score    (score),
    .TriesLeft(tries_left),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_flags"}, {29'd0, correct, wrong, fail}, 0);
    check({tag, "_round_done"}, 32'(round_done), 0);
    check({tag, "_score"}, 32'(score), 0);
    check({tag, "_tries"}, 32'(tries_left), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; submit = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_target = 0; m_tries = 0; m_score = 0;
  endtask

  task automatic start_round(input string tag, input logic [3:0] s);
    @(negedge clk);
    start = 1'b1; sum = s;
    @(negedge clk);
    start = 1'b0;
    sum = s ^ 4'd7;  // Sum wanders mid-round; the captured target must not
    m_target = int'(s);
    m_tries = MT;
    check({tag, "_start_busy"}, 32'(busy), 1);
    check({tag, "_start_tries"}, 32'(tries_left), MT);
    check({tag, "_start_flags"}, {29'd0, correct, wrong, fail}, 0);
  endtask

  // Submit one answer and watch the following RC+2 cycles.
  task automatic run_submit(input string tag, input logic [3:0] a, input int exp_kind,
                            input int exp_tries, input int exp_score, input bit noise);
    int n_ok, n_bad, n_fail, n_rd, rd_at, first_at;
    n_ok = 0; n_bad = 0; n_fail = 0; n_rd = 0; rd_at = -1; first_at = -1;
    @(negedge clk);
    submit = 1'b1; answer = a;
    @(negedge clk);
    submit = 1'b0;
    for (int i = 0; i < RC + 2; i++) begin
      if (correct) n_ok++;
      if (wrong) n_bad++;
      if (fail) n_fail++;
      if ((correct || wrong || fail) && first_at < 0) first_at = i;
      if (round_done) begin n_rd++; rd_at = i; end
      if (noise && i == 1) begin
        submit = 1'b1; start = 1'b1;
        answer = 4'(m_target); sum = 4'($urandom_range(0, 15));
      end else begin
        submit = 1'b0; start = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, "_ok_len"}, n_ok, (exp_kind == K_OK) ? RC : 0);
    check({tag, "_bad_len"}, n_bad, (exp_kind == K_BAD) ? RC : 0);
    check({tag, "_fail_len"}, n_fail, (exp_kind == K_FAIL) ? RC : 0);
    check({tag, "_latency"}, first_at, 0);
    check({tag, "_round_done_cnt"}, n_rd, (exp_kind == K_BAD) ? 0 : 1);
    if (exp_kind != K_BAD) check({tag, "_round_done_at"}, rd_at, RC);
    check({tag, "_tries"}, 32'(tries_left), exp_tries);
    check({tag, "_score"}, 32'(score), exp_score);
    check({tag, "_busy_after"}, 32'(busy), (exp_kind == K_BAD) ? 1 : 0);
  endtask

  // Round-level rule model: judge one answer, update target/tries/score.
  function automatic int model_submit(input int a);
    if (a == m_target) begin
      m_score = (m_score >= 15) ? 15 : m_score + 1;
      return K_OK;
    end
    m_tries = m_tries - 1;
    return (m_tries == 0) ? K_FAIL : K_BAD;
  endfunction

  initial begin
    int rd_seen, kind, a, t;
    rst = 1'b1; start = 1'b0; submit = 1'b0; sum = 4'd0; answer = 4'd0;
    vecs[0] = '{1'b1, 4'd5,  4'd5,  K_OK,   3, 1};
    vecs[1] = '{1'b1, 4'd9,  4'd3,  K_BAD,  2, 1};
    vecs[2] = '{1'b0, 4'd9,  4'd3,  K_BAD,  1, 1};
    vecs[3] = '{1'b0, 4'd9,  4'd3,  K_FAIL, 0, 1};
    vecs[4] = '{1'b1, 4'd0,  4'd0,  K_OK,   3, 2};
    vecs[5] = '{1'b1, 4'd15, 4'd14, K_BAD,  2, 2};
    vecs[6] = '{1'b0, 4'd15, 4'd15, K_OK,   2, 3};
    vecs[7] = '{1'b1, 4'd2,  4'd0,  K_BAD,  2, 3};
    vecs[8] = '{1'b0, 4'd2,  4'd2,  K_OK,   2, 4};
    vecs[9] = '{1'b1, 4'd12, 4'd1,  K_BAD,  2, 4};

    repeat (2) @(negedge clk);
    do_reset();
    check_all_zero("reset");
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));

    // directed vector table
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].new_round) start_round($sformatf("v%0d", i), vecs[i].sum);
      run_submit($sformatf("v%0d", i), vecs[i].ans, vecs[i].kind,
                 vecs[i].tries, vecs[i].score, (i % 2) == 1);
    end

    // Start and Submit together in IDLE: Start wins, no result shown
    do_reset();
    @(negedge clk);
    start = 1'b1; submit = 1'b1; sum = 4'd6; answer = 4'd6;
    @(negedge clk);
    start = 1'b0; submit = 1'b0;
    repeat (2) @(negedge clk);
    check("start_submit_busy", 32'(busy), 1);
    check("start_submit_flags", {29'd0, correct, wrong, fail}, 0);
    check("start_submit_score", 32'(score), 0);
    run_submit("start_submit_then", 4'd6, K_OK, MT, 1, 1'b0);

    // Submit in IDLE is ignored
    @(negedge clk);
    submit = 1'b1; answer = 4'd6;
    @(negedge clk);
    submit = 1'b0;
    check("idle_submit_busy", 32'(busy), 0);
    check("idle_submit_flags", {29'd0, correct, wrong, fail}, 0);
    check("idle_submit_score", 32'(score), 1);

    // reset in the middle of SHOW_OK
    start_round("rst_show", 4'd4);
    @(negedge clk);
    submit = 1'b1; answer = 4'd4;
    @(negedge clk);
    submit = 1'b0;
    check("rst_show_correct_before", 32'(correct), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("rst_show");
    rd_seen = 0;
    repeat (RC + 2) begin
      @(negedge clk);
      if (round_done || busy) rd_seen++;
    end
    check("rst_show_quiet_after", rd_seen, 0);

    // score saturation across 16 wins
    do_reset();
    for (int r = 1; r <= 16; r++) begin
      start_round($sformatf("sat%0d", r), 4'(r));
      run_submit($sformatf("sat%0d", r), 4'(r), K_OK, MT, (r > 15) ? 15 : r, 1'b0);
    end

    // randomized rounds against the reference model
    do_reset();
    for (int r = 0; r < 25; r++) begin
      t = $urandom_range(0, 15);
      start_round($sformatf("rnd%0d", r), 4'(t));
      for (int s = 0; s < MT; s++) begin
        a = ($urandom_range(0, 2) == 0) ? t : $urandom_range(0, 15);
        kind = model_submit(a);
        run_submit($sformatf("rnd%0d_%0d", r, s), 4'(a), kind, m_tries, m_score,
                   ($urandom_range(0, 1) == 1));
        if (kind != K_BAD) break;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/answer_checker.md
ANSWER_CHECKER -- requirements
Module: answer_checker

Interface
REQ-001 Parameter MAX_TRIES, default 3, wrong submissions allowed per round (legal 1..3).
REQ-002 Parameter RESULT_CYCLES, default 4, cycles each result flag is held (legal 1..15).
REQ-003 Clk  input  1  system clock; all state changes on rising edge.
REQ-004 Rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 Start  input  1  single-cycle pulse; begin round, capture Sum as target.
REQ-006 Sum  input  4  problem result from the adder stage (overflow already clamped to 0).
REQ-007 Answer  input  4  player's switch value.
REQ-008 Submit  input  1  single-cycle pulse (already debounced/one-shot); evaluate Answer.
REQ-009 Busy  output  1  high in every state except IDLE.
REQ-010 Correct  output  1  high while showing a correct result.
REQ-011 Wrong  output  1  high while showing a wrong, non-final result.
REQ-012 Fail  output  1  high while showing the final wrong result of a round.
REQ-013 RoundDone  output  1  one-cycle pulse when a round ends (win or fail).
REQ-014 Score  output  4  rounds won, saturating.
REQ-015 TriesLeft  output  2  remaining wrong submissions in current round.

Function
REQ-016 States: IDLE, WAIT, SHOW_OK, SHOW_BAD, SHOW_FAIL; all outputs registered.
REQ-017 IDLE: Start=1 -> Target<=Sum, TriesLeft<=MAX_TRIES, next WAIT; Submit ignored; Start and Submit together -> Start wins.
REQ-018 Start outside IDLE shall be ignored (no retarget, no restart).
REQ-019 WAIT: Submit=1 with Answer==Target -> Score<=Score+1 saturating at 15, next SHOW_OK.
REQ-020 WAIT: Submit=1 with Answer!=Target -> TriesLeft<=TriesLeft-1; next SHOW_FAIL if TriesLeft was 1, else SHOW_BAD.
REQ-021 Latency: Submit sampled at edge N -> flag high from cycle after N for exactly RESULT_CYCLES cycles.
REQ-022 Only the flag of the current SHOW_* state is high; all three flags low in IDLE and WAIT.
REQ-023 Submit and Start during any SHOW_* state ignored.
REQ-024 SHOW_OK expiry -> IDLE with RoundDone pulse on the same edge; SHOW_FAIL expiry -> IDLE with RoundDone pulse; SHOW_BAD expiry -> WAIT, no pulse.
REQ-025 Target held constant for whole round; Sum changes mid-round have no effect.
REQ-026 Target value 0 is a legitimate answer (clamped overflow); Answer 0 matches it.
REQ-027 Score at 15 stays 15 on further wins; Score never decrements.
REQ-028 TriesLeft holds its value through SHOW_* and IDLE until next Start.

Reset
REQ-029 Rst=1 at an edge -> state IDLE, Score=0, TriesLeft=0, Target=0, Busy/Correct/Wrong/Fail/RoundDone=0, hold counter=0.
REQ-030 Rst overrides all inputs, including mid-round and mid-SHOW; no RoundDone pulse on reset.

Structure
REQ-031 Shared include game_defs.vh holds state encodings and MAX_TRIES/RESULT_CYCLES defaults, reused by the game controller.
REQ-032 Hold timing in one sub-module result_timer: load RESULT_CYCLES, count down, assert Done at expiry; synchronous active-high reset.

Verification
REQ-033 Rst, Sum=5, Start, Answer=5 Submit -> Correct high 4 cycles, RoundDone pulse, Score=1, Busy low.
REQ-034 Sum=9, Start, Answer=3 Submit x3 (after each hold) -> Wrong, Wrong, Fail; TriesLeft 2,1,0; RoundDone once; Score unchanged.
REQ-035 Sum=0 Start, Answer=0 Submit -> Correct; Sum changed to 7 mid-WAIT has no effect.
REQ-036 16 consecutive won rounds -> Score 15 after 15th and after 16th.
REQ-037 Start+Submit same cycle in IDLE -> WAIT, no flag; Submit during SHOW_BAD ignored; Rst during SHOW_OK -> all outputs 0 next cycle, no RoundDone.
